// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Holds FSM state encodings, the default price table and a price-extract helper.
package vend_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LIST_MAX_W = 1024;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_PAY      = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_REFUND   = 3'd5
  } state_e;

  // Eight 7-bit prices, product 0 in the least significant slot.
  localparam logic [55:0] DEFAULT_PRICE_LIST = {
    7'd50, 7'd50, 7'd50, 7'd25, 7'd50, 7'd50, 7'd80, 7'd10
  };

  // Returns the w-bit field at slot idx; slots past the list read as 0.
  function automatic logic [31:0] price_at(input logic [LIST_MAX_W-1:0] list,
                                           input int unsigned idx,
                                           input int unsigned w);
    return 32'(list >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Front-end <-> controller bundle. Audit outputs exist only when
// VEND_AUDIT_EN is defined.
interface vend_ctrl_multi_if #(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned PRICE_W      = 7
);
  localparam int unsigned CODE_W = $clog2(NUM_PRODUCTS);

  logic               i_start;
  logic               i_cancel;
  logic [CODE_W-1:0]  i_product_code;
  logic               i_coin_valid;
  logic [PRICE_W-1:0] i_coin_value;
  logic               i_online_payment;
  logic               i_restock;

  logic [2:0]         o_state;
  logic               o_dispense_product;
  logic [CODE_W-1:0]  o_product_id;
  logic [PRICE_W-1:0] o_product_price;
  logic [PRICE_W-1:0] o_credit;
  logic [PRICE_W-1:0] o_return_change;
  logic               o_change_valid;
  logic               o_sold_out;
  logic               o_coin_reject;
`ifdef VEND_AUDIT_EN
  logic [15:0]        o_sales_total;
  logic [15:0]        o_sales_count;
`endif

  modport master (
    output i_start, i_cancel, i_product_code, i_coin_valid, i_coin_value,
           i_online_payment, i_restock,
    input  o_state, o_dispense_product, o_product_id, o_product_price, o_credit,
           o_return_change, o_change_valid, o_sold_out, o_coin_reject
`ifdef VEND_AUDIT_EN
    , input o_sales_total, o_sales_count
`endif
  );

  modport slave (
    input  i_start, i_cancel, i_product_code, i_coin_valid, i_coin_value,
           i_online_payment, i_restock,
    output o_state, o_dispense_product, o_product_id, o_product_price, o_credit,
           o_return_change, o_change_valid, o_sold_out, o_coin_reject
`ifdef VEND_AUDIT_EN
    , output o_sales_total, o_sales_count
`endif
  );

endinterface

// File: rtl/vend_inventory.sv
// Per-product stock counters: restock to full, decrement on dispense
// (saturating at zero), and a combinational empty flag for one product.
module vend_inventory #(
  parameter int unsigned NUM_PRODUCTS = 8,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned INIT_STOCK   = 4,
  localparam int unsigned CODE_W      = $clog2(NUM_PRODUCTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restock,
  input  logic [CODE_W-1:0] restock_idx,
  input  logic              dec,
  input  logic [CODE_W-1:0] dec_idx,
  input  logic [CODE_W-1:0] rd_idx,
  output logic              rd_zero_c
);

  logic [STOCK_W-1:0] stock [NUM_PRODUCTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PRODUCTS; k++) stock[k] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int k = 0; k < NUM_PRODUCTS; k++) begin
        if (restock && restock_idx == CODE_W'(k))
          stock[k] <= '1;
        else if (dec && dec_idx == CODE_W'(k) && stock[k] != '0)
          stock[k] <= stock[k] - STOCK_W'(1);
      end
    end
  end

  // Codes with no matching slot read as empty so they report sold out.
  always_comb begin
    rd_zero_c = 1'b1;
    for (int k = 0; k < NUM_PRODUCTS; k++)
      if (rd_idx == CODE_W'(k)) rd_zero_c = (stock[k] == '0);
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, online payment,
// cancel/timeout refund and change return. Define VEND_AUDIT_EN for sales counters.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS   = 8,
  parameter int unsigned PRICE_W        = 7,
  parameter int unsigned STOCK_W        = 4,
  parameter int unsigned INIT_STOCK     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICE_LIST =
    (NUM_PRODUCTS*PRICE_W)'(DEFAULT_PRICE_LIST)
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vend_ctrl_multi_if.slave bus
);

  localparam int unsigned CODE_W = $clog2(NUM_PRODUCTS);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state;
  logic [CODE_W-1:0]  product_id;
  logic [PRICE_W-1:0] product_price;
  logic [PRICE_W-1:0] credit;
  logic [PRICE_W-1:0] return_change;
  logic               dispense;
  logic               change_valid;
  logic               sold_out;
  logic               coin_reject;
  logic               online_paid;
  logic [CNT_W-1:0]   to_cnt;

  logic [PRICE_W-1:0] sel_price_c;
  logic [PRICE_W:0]   coin_sum_c;
  logic               coin_ok_c;
  logic               code_valid_c;
  logic               stock_zero_c;

  // Coin is accepted only in PAY, with no cancel/online, and without credit overflow.
  always_comb begin
    sel_price_c  = PRICE_W'(price_at(LIST_MAX_W'(PRICE_LIST), 32'(bus.i_product_code), PRICE_W));
    coin_sum_c   = {1'b0, credit} + {1'b0, bus.i_coin_value};
    coin_ok_c    = (state == ST_PAY) && bus.i_coin_valid && !bus.i_cancel &&
                   !bus.i_online_payment && !coin_sum_c[PRICE_W];
    code_valid_c = 32'(product_id) < NUM_PRODUCTS;
  end

  vend_inventory #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .STOCK_W      (STOCK_W),
    .INIT_STOCK   (INIT_STOCK)
  ) u_inventory (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .restock     ((state == ST_IDLE) && bus.i_restock && !bus.i_start),
    .restock_idx (bus.i_product_code),
    .dec         (state == ST_DISPENSE),
    .dec_idx     (product_id),
    .rd_idx      (product_id),
    .rd_zero_c   (stock_zero_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      product_id    <= '0;
      product_price <= '0;
      credit        <= '0;
      return_change <= '0;
      dispense      <= 1'b0;
      change_valid  <= 1'b0;
      sold_out      <= 1'b0;
      coin_reject   <= 1'b0;
      online_paid   <= 1'b0;
      to_cnt        <= '0;
    end else begin
      dispense      <= 1'b0;
      change_valid  <= 1'b0;
      sold_out      <= 1'b0;
      return_change <= '0;
      coin_reject   <= bus.i_coin_valid && !coin_ok_c;
      if (state != ST_PAY) to_cnt <= '0;
      if (coin_ok_c) credit <= coin_sum_c[PRICE_W-1:0];

      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            product_id    <= bus.i_product_code;
            product_price <= sel_price_c;
            online_paid   <= 1'b0;
            state         <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!code_valid_c || stock_zero_c) begin
            sold_out <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_PAY;
          end
        end
        // Refund/change outputs are registered on entry so they line up with the state.
        ST_PAY: begin
          if (bus.i_cancel) begin
            change_valid  <= 1'b1;
            return_change <= credit;
            state         <= ST_REFUND;
          end else if (bus.i_online_payment) begin
            online_paid <= 1'b1;
            dispense    <= 1'b1;
            state       <= ST_DISPENSE;
          end else if (credit >= product_price) begin
            dispense <= 1'b1;
            state    <= ST_DISPENSE;
          end else if (coin_ok_c) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            change_valid  <= 1'b1;
            return_change <= credit;
            state         <= ST_REFUND;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        ST_DISPENSE: begin
          change_valid  <= 1'b1;
          return_change <= online_paid ? '0 : credit - product_price;
          state         <= ST_CHANGE;
        end
        ST_CHANGE, ST_REFUND: begin
          credit <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_total;
  logic [15:0] sales_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sales_total <= '0;
      sales_count <= '0;
    end else if (state == ST_DISPENSE) begin
      sales_total <= sales_total + 16'(product_price);
      sales_count <= sales_count + 16'd1;
    end
  end

  assign bus.o_sales_total = sales_total;
  assign bus.o_sales_count = sales_count;
`endif

  assign bus.o_state            = state;
  assign bus.o_dispense_product = dispense;
  assign bus.o_product_id       = product_id;
  assign bus.o_product_price    = product_price;
  assign bus.o_credit           = credit;
  assign bus.o_return_change    = return_change;
  assign bus.o_change_valid     = change_valid;
  assign bus.o_sold_out         = sold_out;
  assign bus.o_coin_reject      = coin_reject;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_vend_ctrl_multi;

  localparam int unsigned NP = 8;
  localparam int unsigned PW = 7;
  localparam int unsigned TO = 20;
  // Product 7 raised to 120 so a 100 credit stays below price.
  localparam logic [NP*PW-1:0] PLIST = {
    7'd120, 7'd50, 7'd50, 7'd25, 7'd50, 7'd50, 7'd80, 7'd10
  };

  localparam int K_REJ  = 0;
  localparam int K_DISP = 1;
  localparam int K_CHG  = 2;
  localparam int K_SOLD = 3;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  ev_t  exp_q [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.NUM_PRODUCTS(NP), .PRICE_W(PW)) bus ();

  vend_ctrl_multi #(
    .NUM_PRODUCTS   (NP),
    .PRICE_W        (PW),
    .STOCK_W        (4),
    .INIT_STOCK     (4),
    .TIMEOUT_CYCLES (TO),
    .PRICE_LIST     (PLIST)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int value);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d value %0d, expected no event", kind, value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value) begin
        errors++;
        $display("FAIL sb_event: got kind %0d value %0d, expected kind %0d value %0d",
                 kind, value, e.kind, e.value);
      end
    end
  endtask

  // Same-cycle pulses are compared in a fixed order: reject, dispense, change, sold-out.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_coin_reject)      sb_check(K_REJ, 0);
      if (bus.o_dispense_product) sb_check(K_DISP, int'(bus.o_product_id));
      if (bus.o_change_valid)     sb_check(K_CHG, int'(bus.o_return_change));
      if (bus.o_sold_out)         sb_check(K_SOLD, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.o_state != 3'd0 && n < budget) begin
      tick();
      n++;
    end
    check("reach_idle", int'(bus.o_state), 0);
  endtask

  task automatic drain();
    tick();
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic start(input int code);
    bus.i_start        = 1'b1;
    bus.i_product_code = 3'(code);
    tick();
    bus.i_start = 1'b0;
    check("state_check", int'(bus.o_state), 1);
  endtask

  task automatic coin(input int v);
    bus.i_coin_valid = 1'b1;
    bus.i_coin_value = 7'(v);
    tick();
    bus.i_coin_valid = 1'b0;
  endtask

  task automatic purchase(input int code, input int v, input int n, input int chg);
    push(K_DISP, code);
    push(K_CHG, chg);
    start(code);
    tick();
    for (int i = 0; i < n; i++) coin(v);
    wait_idle(10);
    check("credit_after_buy", int'(bus.o_credit), 0);
    drain();
  endtask

  task automatic sold_out_check(input int code);
    push(K_SOLD, 0);
    start(code);
    tick();
    check("sold_out_idle", int'(bus.o_state), 0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.i_start = 1'b0; bus.i_cancel = 1'b0; bus.i_product_code = '0;
    bus.i_coin_valid = 1'b0; bus.i_coin_value = '0;
    bus.i_online_payment = 1'b0; bus.i_restock = 1'b0;
    tick(); tick();
    check("rst_state", int'(bus.o_state), 0);
    check("rst_credit", int'(bus.o_credit), 0);
    check("rst_change_valid", int'(bus.o_change_valid), 0);
    check("rst_dispense", int'(bus.o_dispense_product), 0);
    rst_n = 1'b1;
    tick();

    // Coin in IDLE is always rejected.
    push(K_REJ, 0);
    coin(10);
    drain();

    // p4 (25) with three 10s: change 5.
    push(K_DISP, 4);
    push(K_CHG, 5);
    start(4);
    check("price_p4", int'(bus.o_product_price), 25);
    tick();
    coin(10); coin(10); coin(10);
    check("credit_30", int'(bus.o_credit), 30);
    wait_idle(10);
    check("credit_clear", int'(bus.o_credit), 0);
    drain();

    // p1 (80), coin 50, cancel: refund 50.
    push(K_CHG, 50);
    start(1);
    tick();
    coin(50);
    check("credit_50", int'(bus.o_credit), 50);
    bus.i_cancel = 1'b1;
    tick();
    bus.i_cancel = 1'b0;
    check("state_refund", int'(bus.o_state), 5);
    wait_idle(10);
    check("credit_after_cancel", int'(bus.o_credit), 0);
    drain();

    // p0 online payment with a coin in the same cycle.
    push(K_REJ, 0);
    push(K_DISP, 0);
    push(K_CHG, 0);
    start(0);
    tick();
    bus.i_online_payment = 1'b1;
    bus.i_coin_valid = 1'b1;
    bus.i_coin_value = 7'd10;
    tick();
    bus.i_online_payment = 1'b0;
    bus.i_coin_valid = 1'b0;
    check("state_dispense", int'(bus.o_state), 3);
    wait_idle(10);
    drain();

    // Remaining three p4 units, then sold out, then restock.
    for (int i = 0; i < 3; i++) purchase(4, 25, 1, 0);
    sold_out_check(4);
    bus.i_restock = 1'b1;
    bus.i_product_code = 3'd4;
    tick();
    bus.i_restock = 1'b0;
    purchase(4, 5, 5, 0);

    // p7 (120): coin 100 then 50 overflows, timeout refunds 100.
    push(K_REJ, 0);
    push(K_CHG, 100);
    start(7);
    tick();
    coin(100);
    coin(50);
    check("credit_hold_100", int'(bus.o_credit), 100);
    for (int i = 0; i < 18; i++) tick();
    check("timeout_last_pay", int'(bus.o_state), 2);
    tick();
    check("timeout_refund", int'(bus.o_state), 5);
    wait_idle(10);
    drain();

    // Reset mid-PAY discards credit silently and reloads stock.
    start(1);
    tick();
    coin(40);
    check("credit_40", int'(bus.o_credit), 40);
    rst_n = 1'b0;
    #2;
    check("midrst_state", int'(bus.o_state), 0);
    check("midrst_credit", int'(bus.o_credit), 0);
    check("midrst_change_valid", int'(bus.o_change_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) purchase(4, 25, 1, 0);
    sold_out_check(4);

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised next-generation vending controller: N products with per-product price and stock, per-cycle coin insertion with running credit, online payment, cancel/timeout refund, and change return.
Sits between the coin/payment front-end and the dispense actuator.
Replaces the single-shot "total coin value" model with incremental credit accumulation and inventory tracking.

Parameters:
NUM_PRODUCTS, 8, number of selectable products (>=2)
PRICE_W, 7, width of price, coin, credit and change values
STOCK_W, 4, width of each per-product stock counter
INIT_STOCK, 4, stock loaded into every product on reset
TIMEOUT_CYCLES, 1000, idle cycles allowed in PAY before auto-refund
PRICE_LIST, {8 x PRICE_W}, packed prices; product k at bits [k*PRICE_W +: PRICE_W]; default p0=10, p1=80, p4=25, others 50

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  begin transaction with i_product_code (sampled in IDLE)
i_cancel  in  1  abort transaction, refund credit
i_product_code  in  $clog2(NUM_PRODUCTS)  product select
i_coin_valid  in  1  one coin this cycle
i_coin_value  in  PRICE_W  coin value, qualified by i_coin_valid
i_online_payment  in  1  full payment confirmed externally
i_restock  in  1  in IDLE, set stock of i_product_code to all-ones
o_state  out  3  current FSM state
o_dispense_product  out  1  one-cycle dispense pulse
o_product_id  out  $clog2(NUM_PRODUCTS)  latched product
o_product_price  out  PRICE_W  price of latched product
o_credit  out  PRICE_W  accumulated credit
o_return_change  out  PRICE_W  change/refund value, qualified by o_change_valid
o_change_valid  out  1  one-cycle change pulse
o_sold_out  out  1  one-cycle pulse: selected product out of stock or invalid code
o_coin_reject  out  1  one-cycle pulse: coin not accepted, returned physically

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; credit 0; timeout counter 0; every stock = INIT_STOCK. Reset mid-transaction discards credit without change pulse.
- All outputs registered; o_state encodings: IDLE=0, CHECK=1, PAY=2, DISPENSE=3, CHANGE=4, REFUND=5.
- IDLE: i_start -> latch code/price, go CHECK. i_restock without i_start -> stock[code]=2^STOCK_W-1. i_start wins over i_restock.
- CHECK (1 cycle): code>=NUM_PRODUCTS or stock==0 -> o_sold_out pulse, IDLE; else PAY.
- PAY, priority high->low: i_cancel -> REFUND; i_online_payment -> DISPENSE, change 0, coins this cycle rejected; credit>=price -> DISPENSE; accepted coin -> credit+=coin, timeout counter cleared; counter==TIMEOUT_CYCLES-1 -> REFUND.
- Coin acceptance: only in PAY, no cancel/online this cycle, and credit+coin <= 2^PRICE_W-1 (computed PRICE_W+1 bits). Otherwise o_coin_reject next cycle; credit unchanged. Coins outside PAY always rejected.
- Credit check uses registered credit: coin at cycle k makes credit>=price at k+1, DISPENSE at k+2.
- DISPENSE (1 cycle): o_dispense_product=1, stock[id] decremented (never below 0), go CHANGE.
- CHANGE (1 cycle): o_return_change=credit-price (0 for online), o_change_valid=1, credit cleared, IDLE.
- REFUND (1 cycle): o_return_change=credit, o_change_valid=1 even when credit 0, no dispense, stock unchanged, credit cleared, IDLE.
- i_start outside IDLE ignored; i_cancel outside PAY ignored.

Optional Feature:
VEND_AUDIT_EN: when defined, adds o_sales_total (16 bits, wraps) summing prices of dispensed products and o_sales_count (16 bits, wraps) counting dispenses; both cleared on reset. When undefined, ports and counters absent; all other behaviour identical.

Decomposition:
- Package vend_pkg: state encodings, state typedef, default PRICE_LIST constant, price-extract function.
- Sub-module vend_inventory: NUM_PRODUCTS x STOCK_W stock array, restock/decrement/read-zero logic, async reset to INIT_STOCK.

Test Plan:
- Start p4 (price 25), coins 10,10,10 -> credit 30, dispense pulse, change 5, stock[4] 4->3.
- Start p1 (price 80), coins 50, then i_cancel -> no dispense, refund 50, credit 0, state IDLE.
- Start p0 with i_online_payment in PAY plus coin 10 same cycle -> dispense, change 0, o_coin_reject pulse.
- Buy p4 four times, fifth start -> o_sold_out after CHECK, back to IDLE; i_restock on p4 -> next purchase succeeds.
- Coins 100 then 50 (PRICE_W=7, max 127) -> second coin rejected, credit stays 100; TIMEOUT_CYCLES=20 with no coins after that -> REFUND 100.
- i_rst_n low mid-PAY with credit 40 -> state 0, credit 0, no change pulse, stocks back to 4.
